kitchen_order_scheduler: RTL and testbench
==========================================

Name: kitchen_order_scheduler

Overview:
Front-end scheduler for the kitchen's single cooking station. Collects order requests from NUM_TABLES table requesters via round-robin arbitration and buffers accepted orders in a FIFO. It then sequences the station one order at a time through cook → ready → serve using start/ready/done handshakes. It sits between the table-side order inputs and the cook-station order FSM.

Parameters:
NUM_TABLES, 4, number of requesting tables (power of 2, ≥2)
TABLE_W, 2, width of table index = log2(NUM_TABLES)
QUEUE_DEPTH, 4, FIFO entries (power of 2, ≥2)
CNT_W, 3, width of queue_count = log2(QUEUE_DEPTH)+1

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
order_req  in  NUM_TABLES  per-table level request; held until matching order_ack seen
order_ack  out  NUM_TABLES  one-hot, one-cycle pulse: order from that table accepted into queue
cook_start  out  1  one-cycle pulse: station begins order for cook_table
cook_table  out  TABLE_W  table index of order in progress; valid while state≠IDLE
food_ready  in  1  station reports food cooked (sampled only in COOK)
serve_done  in  1  server reports delivery (sampled only in READY)
serve_valid  out  1  high in READY: food for cook_table awaiting pickup
queue_count  out  CNT_W  number of orders buffered (0..QUEUE_DEPTH)
queue_full  out  1  queue_count==QUEUE_DEPTH
state_out  out  2  station state: 00 IDLE, 01 COOK, 10 READY

Behaviour:
- Reset (synchronous, dominant over all other inputs, including mid-operation): queue flushed (rd/wr ptr=0, count=0), state IDLE, rr pointer=0, and all outputs 0 (order_ack, cook_start, cook_table, serve_valid, queue_count, queue_full, state_out). Any in-flight order is dropped.
- Arbitration, evaluated every cycle:
  - Eligible set = order_req & ~order_ack. A table whose ack is high this cycle cannot be granted again.
  - If queue_full=0 and eligible≠0, grant the first eligible table searching upward (with wrap) from rr pointer.
  - On the clock edge: write the granted index at wr_ptr, increment wr_ptr (wraps at QUEUE_DEPTH), register order_ack[g]=1 for the next cycle, and set rr pointer=g+1 mod NUM_TABLES.
  - At most one grant per cycle. When queue_full=1, no grant is made and requests simply wait.
- Full is evaluated on the registered count at the start of the cycle. A pop in the same cycle does NOT enable a push.
- Station FSM:
  - IDLE: if queue_count>0 → pop head into cook_table, increment rd_ptr (with wrap), pulse cook_start for one cycle (registered, coincides with first COOK cycle), go to COOK. Otherwise stay in IDLE.
  - COOK: food_ready=1 → READY; else stay.
  - READY: serve_valid=1. serve_done=1 → IDLE; else stay.
  - No state lingers: the cycle after returning to IDLE may pop again.
  - Unused encoding 11 → IDLE.
- Count update: push-only +1, pop-only −1, push and pop in the same cycle → unchanged.
- Latency from empty and idle: req sampled at edge E → ack high E..E+1; cook_start and state COOK from edge E+1.
- Out-of-state inputs have no effect: food_ready outside COOK, serve_done outside READY.
- Orders are served in strict FIFO order of acceptance.

Test Plan:
- Reset then single order: order_req=0100 held until ack → order_ack=0100 for exactly 1 cycle; next cycle cook_start=1, cook_table=2, state_out=01; food_ready → state 10, serve_valid=1; serve_done → state 00, queue_count=0.
- Round-robin: all four requests held continuously, station stalled in COOK → acks in order 0001,0010,0100,1000 on consecutive cycles; queue_count reaches 3 after the first order pops into COOK, then 4 (queue_full=1) after further grants; no ack while full.
- Full boundary: queue full with table 1 requesting; serve the current order and pop in the same cycle → no ack that cycle, ack for table 1 the following cycle, count stays ≤4.
- FIFO order and wrap: push tables 3,1,2,0,3,1 across two fills → cook_table sequence 3,1,2,0,3,1 across wr/rd pointer wrap.
- Ignored inputs: pulse serve_done in IDLE/COOK and food_ready in IDLE/READY → state_out unchanged.
- Reset mid-operation: assert reset in READY with count=2 → next cycle state 00, count 0, serve_valid 0, order_ack 0; a new request afterwards is granted starting from table 0 priority.

Source files
------------

// File: rtl/kitchen_order_scheduler_if.sv
// kitchen_order_scheduler_if: table-side order handshake plus cook-station start/ready/done signals
interface kitchen_order_scheduler_if #(
  parameter int NUM_TABLES = 4,
  parameter int TABLE_W = 2,
  parameter int CNT_W = 3
);
  logic [NUM_TABLES-1:0] order_req;
  logic [NUM_TABLES-1:0] order_ack;
  logic cook_start;
  logic [TABLE_W-1:0] cook_table;
  logic food_ready;
  logic serve_done;
  logic serve_valid;
  logic [CNT_W-1:0] queue_count;
  logic queue_full;
  logic [1:0] state_out;
  modport master (
    output order_req, food_ready, serve_done,
    input order_ack, cook_start, cook_table, serve_valid, queue_count, queue_full, state_out
  );
  modport slave (
    input order_req, food_ready, serve_done,
    output order_ack, cook_start, cook_table, serve_valid, queue_count, queue_full, state_out
  );
endinterface

// File: rtl/kitchen_order_scheduler.sv
// kitchen_order_scheduler: round-robin order intake into a FIFO feeding a cook/ready/serve station FSM; ports clk, reset, bus (slave: order_req/ack, cook_start/table, food_ready, serve_done, serve_valid, queue_count/full, state_out)
module kitchen_order_scheduler #(
  parameter int NUM_TABLES = 4,
  parameter int TABLE_W = 2,
  parameter int QUEUE_DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic clk,
  input logic reset,
  kitchen_order_scheduler_if.slave bus
);
  localparam int PTR_W = CNT_W - 1;
  typedef enum logic [1:0] {IDLE = 2'b00, COOK = 2'b01, READY = 2'b10} state_t;
  state_t state, state_next;
  logic [TABLE_W-1:0] rr, grant, idx;
  logic [TABLE_W-1:0] mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [NUM_TABLES-1:0] eligible;
  logic found, full, push, pop;
  assign full = count == CNT_W'(QUEUE_DEPTH);
  // a table acked this cycle is still holding its request, so mask it out
  assign eligible = bus.order_req & ~bus.order_ack;
  assign push = found && !full;
  assign bus.queue_count = count;
  assign bus.queue_full = full;
  assign bus.state_out = state;
  assign bus.serve_valid = state == READY;
  always_comb begin
    found = 1'b0;
    grant = rr;
    idx = rr;
    for (int i = 0; i < NUM_TABLES; i++) begin
      idx = rr + TABLE_W'(i);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end
  always_comb begin
    pop = state == IDLE && count != '0;
    state_next = IDLE;
    case (state)
      IDLE: state_next = pop ? COOK : IDLE;
      COOK: state_next = bus.food_ready ? READY : COOK;
      READY: state_next = bus.serve_done ? IDLE : READY;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push && !reset) mem[wr_ptr] <= grant;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      bus.order_ack <= '0;
      bus.cook_start <= 1'b0;
      bus.cook_table <= '0;
    end else begin
      state <= state_next;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      bus.order_ack <= push ? NUM_TABLES'(1) << grant : '0;
      bus.cook_start <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        rr <= grant + TABLE_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        bus.cook_table <= mem[rd_ptr];
      end
    end
  end
endmodule

// File: tb/tb_kitchen_order_scheduler.sv
// tb_kitchen_order_scheduler: directed test-plan steps then randomized traffic checked against a queue-based reference model
module tb_kitchen_order_scheduler;
  localparam int N = 4;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int mq[$];
  int m_st, m_rr, m_ct;
  logic [N-1:0] m_ack;
  logic m_cs;
  logic [N-1:0] req;
  kitchen_order_scheduler_if #(.NUM_TABLES(4), .TABLE_W(2), .CNT_W(3)) bus ();
  kitchen_order_scheduler #(.NUM_TABLES(4), .TABLE_W(2), .QUEUE_DEPTH(4), .CNT_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model(input logic [N-1:0] r, input logic f, input logic s, input logic rs);
    logic [N-1:0] elig;
    int g, ns;
    if (rs) begin
      mq.delete();
      m_st = 0; m_rr = 0; m_ct = 0; m_ack = '0; m_cs = 1'b0;
      return;
    end
    elig = r & ~m_ack;
    g = -1;
    if (mq.size() < DEPTH)
      for (int i = 0; i < N; i++)
        if (g < 0 && elig[(m_rr + i) % N]) g = (m_rr + i) % N;
    ns = m_st;
    m_cs = 1'b0;
    if (m_st == 0 && mq.size() > 0) begin
      m_ct = mq.pop_front();
      m_cs = 1'b1;
      ns = 1;
    end else if (m_st == 1 && f) ns = 2;
    else if (m_st == 2 && s) ns = 0;
    m_st = ns;
    m_ack = '0;
    if (g >= 0) begin
      mq.push_back(g);
      m_ack[g] = 1'b1;
      m_rr = (g + 1) % N;
    end
  endtask
  task automatic step(input logic [N-1:0] r, input logic f, input logic s, input logic rs);
    bus.order_req = r;
    bus.food_ready = f;
    bus.serve_done = s;
    reset = rs;
    model(r, f, s, rs);
    @(posedge clk);
    #1;
    check("order_ack", 8'(bus.order_ack), 8'(m_ack));
    check("cook_start", 8'(bus.cook_start), 8'(m_cs));
    if (m_st != 0) check("cook_table", 8'(bus.cook_table), 8'(m_ct));
    check("serve_valid", 8'(bus.serve_valid), 8'(m_st == 2));
    check("queue_count", 8'(bus.queue_count), 8'(mq.size()));
    check("queue_full", 8'(bus.queue_full), 8'(mq.size() == DEPTH));
    check("state_out", 8'(bus.state_out), 8'(m_st));
  endtask
  initial begin
    bus.order_req = '0;
    bus.food_ready = 1'b0;
    bus.serve_done = 1'b0;
    model('0, 1'b0, 1'b0, 1'b1);
    step('0, 0, 0, 1);
    step('0, 0, 0, 1);
    check("rst_count", 8'(bus.queue_count), 8'd0);
    step(4'b0100, 0, 0, 0);
    check("single_ack", 8'(bus.order_ack), 8'b0100);
    step(4'b0000, 0, 0, 0);
    check("single_start", 8'(bus.cook_start), 8'd1);
    check("single_table", 8'(bus.cook_table), 8'd2);
    step(4'b0000, 1, 0, 0);
    check("single_ready", 8'(bus.state_out), 8'd2);
    step(4'b0000, 0, 1, 0);
    check("single_idle", 8'(bus.state_out), 8'd0);
    step('0, 0, 0, 1);
    for (int i = 0; i < 7; i++) begin
      step(4'b1111, 0, 0, 0);
      if (i == 3) check("rr_ack3", 8'(bus.order_ack), 8'b1000);
      if (i == 3) check("rr_count3", 8'(bus.queue_count), 8'd3);
    end
    check("rr_full", 8'(bus.queue_full), 8'd1);
    check("rr_noack", 8'(bus.order_ack), 8'd0);
    step(4'b0010, 1, 0, 0);
    step(4'b0010, 0, 1, 0);
    step(4'b0010, 0, 0, 0);
    check("full_pop_noack", 8'(bus.order_ack), 8'd0);
    step(4'b0010, 0, 0, 0);
    check("full_next_ack", 8'(bus.order_ack), 8'b0010);
    step(4'b0000, 0, 1, 0);
    check("ign_serve_in_cook", 8'(bus.state_out), 8'd1);
    step(4'b0000, 1, 0, 0);
    step(4'b0000, 1, 0, 0);
    check("ign_ready_in_ready", 8'(bus.state_out), 8'd2);
    step(4'b0000, 0, 0, 1);
    check("mid_rst_state", 8'(bus.state_out), 8'd0);
    check("mid_rst_count", 8'(bus.queue_count), 8'd0);
    step(4'b1111, 0, 0, 0);
    check("post_rst_prio", 8'(bus.order_ack), 8'b0001);
    step(4'b0000, 0, 0, 0);
    req = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        req[i] = m_ack[i] ? 1'($urandom % 2) : (req[i] ? 1'b1 : 1'($urandom % 4 == 0));
      step(req, 1'($urandom % 3 == 0), 1'($urandom % 3 == 0), 1'($urandom % 250 == 0));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
